// File: rtl/fta_resp_router.sv
// Response router: steers a serialized response stream into per-requester FIFOs
// keyed by the low cid bits, with sticky per-port overflow detection.
package fta_pkg;

    typedef struct packed {
        logic         ack;
        logic         stall;
        logic         next;
        logic [3:0]   pri;
        logic [7:0]   cid;
        logic [7:0]   tid;
        logic [127:0] dat;
    } fta_cmd_response128_t;

endpackage

module fta_resp_router
    import fta_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int DEPTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  fta_cmd_response128_t                   resp_i,
    output fta_cmd_response128_t [PORTS-1:0]       resp_o,
    input  logic [PORTS-1:0]                       rdy_i,
    output logic [PORTS-1:0]                       ovf_o,
    input  logic [PORTS-1:0]                       ovf_clr_i,
    output logic [PORTS*($clog2(DEPTH)+1)-1:0]     cnt_o
);

    localparam int PW = $clog2(PORTS);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PW-1:0] dst_s;

    assign dst_s = resp_i.cid[PW-1:0];

    for (genvar p = 0; p < PORTS; p++) begin : g_port
        logic [AW-1:0]        head_r;
        logic [AW-1:0]        tail_r;
        logic [CW-1:0]        cnt_r;
        logic                 ovf_r;
        fta_cmd_response128_t mem_r [DEPTH];
        fta_cmd_response128_t view_s;
        logic                 push_s;
        logic                 pop_s;
        logic                 full_s;
        logic                 accept_s;
        logic                 ovf_set_s;

        // Per-port push/pop qualification; a full port still accepts when it pops.
        always_comb begin
            push_s    = resp_i.ack && (dst_s == PW'(p));
            pop_s     = (cnt_r != CW'(0)) && rdy_i[p];
            full_s    = (cnt_r == CW'(DEPTH));
            accept_s  = push_s && (!full_s || pop_s);
            ovf_set_s = push_s && full_s && !pop_s;
        end

        // Pointer and occupancy state, emptied asynchronously on reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                head_r <= AW'(0);
                tail_r <= AW'(0);
                cnt_r  <= CW'(0);
            end else begin
                if (accept_s) begin
                    tail_r <= tail_r + AW'(1);
                end
                if (pop_s) begin
                    head_r <= head_r + AW'(1);
                end
                case ({accept_s, pop_s})
                    2'b10:   cnt_r <= cnt_r + CW'(1);
                    2'b01:   cnt_r <= cnt_r - CW'(1);
                    default: cnt_r <= cnt_r;
                endcase
            end
        end

        // Sticky overflow flag; a set wins over a simultaneous clear.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ovf_r <= 1'b0;
            end else if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr_i[p]) begin
                ovf_r <= 1'b0;
            end
        end

        // Entry storage is deliberately unreset; the count gates visibility.
        always_ff @(posedge clk) begin
            if (accept_s) begin
                mem_r[tail_r] <= resp_i;
            end
        end

        // Head presentation built purely from registered state.
        always_comb begin
            view_s = '0;
            if (cnt_r != CW'(0)) begin
                view_s       = mem_r[head_r];
                view_s.ack   = 1'b1;
                view_s.stall = 1'b0;
                view_s.next  = 1'b0;
            end else begin
                view_s.pri   = 4'hF;
            end
        end

        assign resp_o[p]            = view_s;
        assign ovf_o[p]             = ovf_r;
        assign cnt_o[p*CW +: CW]    = cnt_r;
    end

endmodule

// File: tb/tb_fta_resp_router.sv
// Scoreboard bench for fta_resp_router: stimulus queues expected head values,
// a negedge monitor checks every delivered response against them.
module tb_fta_resp_router;
    import fta_pkg::*;

    localparam int PORTS = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                             clk;
    logic                             rst;
    fta_cmd_response128_t             resp_i;
    fta_cmd_response128_t [PORTS-1:0] resp_o;
    logic [PORTS-1:0]                 rdy_i;
    logic [PORTS-1:0]                 ovf_o;
    logic [PORTS-1:0]                 ovf_clr_i;
    logic [PORTS*CW-1:0]              cnt_o;

    fta_cmd_response128_t exp_q [PORTS][$];
    fta_cmd_response128_t empty_v;
    int n_checks = 0;
    int n_fail   = 0;

    fta_resp_router #(.PORTS(PORTS), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .resp_i    (resp_i),
        .resp_o    (resp_o),
        .rdy_i     (rdy_i),
        .ovf_o     (ovf_o),
        .ovf_clr_i (ovf_clr_i),
        .cnt_o     (cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] cnt_of(input int p);
        return cnt_o[p*CW +: CW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle push; accept says whether the hand-computed outcome keeps the entry.
    task automatic push(input logic [7:0] cid, input logic [127:0] dat, input logic [7:0] tid,
                        input logic sn, input bit accept);
        fta_cmd_response128_t e;
        int p;
        p = int'(cid) % PORTS;
        resp_i.ack   = 1'b1;
        resp_i.stall = sn;
        resp_i.next  = sn;
        resp_i.pri   = 4'h3;
        resp_i.cid   = cid;
        resp_i.tid   = tid;
        resp_i.dat   = dat;
        if (accept) begin
            e       = resp_i;
            e.stall = 1'b0;
            e.next  = 1'b0;
            exp_q[p].push_back(e);
        end
        step();
        resp_i.ack = 1'b0;
        resp_i.dat = 128'hDEAD_BEEF;
    endtask

    // Monitor: every handshake seen before an edge must match the scoreboard head.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            for (int p = 0; p < PORTS; p++) begin
                if (resp_o[p].ack === 1'b1 && rdy_i[p] === 1'b1) begin
                    if (exp_q[p].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_pop port %0d: got %0h expected none", p, resp_o[p]);
                    end else begin
                        check($sformatf("deliver_p%0d", p), 256'(resp_o[p]), 256'(exp_q[p].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        empty_v     = '0;
        empty_v.pri = 4'hF;
        resp_i      = '0;
        rdy_i       = '0;
        ovf_clr_i   = '0;
        rst         = 1'b0;
        #1 rst      = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_cnt", 256'(cnt_o), 256'(0));
        check("reset_ovf", 256'(ovf_o), 256'(0));
        for (int p = 0; p < PORTS; p++) check($sformatf("reset_resp_p%0d", p), 256'(resp_o[p]), 256'(empty_v));
        rst = 1'b0;

        // Single route to port 2
        push(8'd2, 128'hA5, 8'd7, 1'b1, 1'b1);
        check("route_ack", 256'(resp_o[2].ack), 256'(1));
        check("route_dat", 256'(resp_o[2].dat), 256'hA5);
        check("route_tid", 256'(resp_o[2].tid), 256'd7);
        check("route_others_ack", 256'({resp_o[3].ack, resp_o[1].ack, resp_o[0].ack}), 256'(0));
        check("route_cnt", 256'(cnt_of(2)), 256'(1));
        step();
        check("route_hold_noready", 256'(cnt_of(2)), 256'(1));
        rdy_i[2] = 1'b1;
        step();
        rdy_i[2] = 1'b0;
        check("route_drained", 256'(cnt_of(2)), 256'(0));

        // Order and back-to-back pop on port 1
        push(8'd1, 128'd1, 8'd11, 1'b0, 1'b1);
        push(8'd1, 128'd2, 8'd12, 1'b0, 1'b1);
        push(8'd1, 128'd3, 8'd13, 1'b0, 1'b1);
        rdy_i[1] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("order_dat%0d", k), 256'(resp_o[1].dat), 256'(k));
            step();
        end
        rdy_i[1] = 1'b0;
        check("order_empty_ack", 256'(resp_o[1].ack), 256'(0));
        check("order_empty_cnt", 256'(cnt_of(1)), 256'(0));

        // Overflow on port 0
        for (int k = 0; k < 5; k++) push(8'd0, 128'(10 + k), 8'(k), 1'b0, k < 4);
        check("ovf_cnt", 256'(cnt_of(0)), 256'(4));
        check("ovf_flag", 256'(ovf_o[0]), 256'(1));
        check("ovf_head", 256'(resp_o[0].dat), 256'd10);
        check("ovf_other_cnt", 256'({cnt_of(3), cnt_of(2), cnt_of(1)}), 256'(0));
        ovf_clr_i[0] = 1'b1;
        push(8'd0, 128'd15, 8'd5, 1'b0, 1'b0);
        ovf_clr_i[0] = 1'b0;
        check("ovf_set_beats_clr", 256'(ovf_o[0]), 256'(1));
        ovf_clr_i[0] = 1'b1;
        step();
        ovf_clr_i[0] = 1'b0;
        check("ovf_cleared", 256'(ovf_o[0]), 256'(0));
        rdy_i[0] = 1'b1;
        repeat (4) step();
        rdy_i[0] = 1'b0;
        check("ovf_drained", 256'(cnt_of(0)), 256'(0));

        // Full port 3 with simultaneous push and pop
        for (int k = 0; k < 4; k++) push(8'd3, 128'(20 + k), 8'(k), 1'b0, 1'b1);
        rdy_i[3] = 1'b1;
        push(8'd3, 128'd24, 8'd4, 1'b0, 1'b1);
        rdy_i[3] = 1'b0;
        check("fullpp_cnt", 256'(cnt_of(3)), 256'(4));
        check("fullpp_ovf", 256'(ovf_o[3]), 256'(0));
        rdy_i[3] = 1'b1;
        repeat (4) step();
        rdy_i[3] = 1'b0;
        check("fullpp_drained", 256'(cnt_of(3)), 256'(0));

        // Wrap-around on port 1, upper cid bits varied and ignored
        for (int i = 0; i < 10; i++) begin
            rdy_i[1] = (i > 0);
            push(8'h01 | 8'(i << 2), 128'(100 + i), 8'(i), 1'b0, 1'b1);
        end
        rdy_i[1] = 1'b1;
        step();
        rdy_i[1] = 1'b0;
        check("wrap_drained", 256'(cnt_of(1)), 256'(0));

        // Reset mid-stream with port 2 holding three entries
        for (int k = 0; k < 3; k++) push(8'd2, 128'(30 + k), 8'(k), 1'b0, 1'b1);
        check("prerst_cnt", 256'(cnt_of(2)), 256'(3));
        rst = 1'b1;
        #1;
        exp_q[2].delete();
        check("rst_ack", 256'(resp_o[2].ack), 256'(0));
        check("rst_pri", 256'(resp_o[2].pri), 256'hF);
        check("rst_cnt", 256'(cnt_of(2)), 256'(0));
        step();
        rst = 1'b0;
        push(8'd2, 128'h77, 8'd9, 1'b0, 1'b1);
        check("postrst_dat", 256'(resp_o[2].dat), 256'h77);
        check("postrst_cnt", 256'(cnt_of(2)), 256'(1));
        rdy_i[2] = 1'b1;
        step();
        rdy_i[2] = 1'b0;
        check("postrst_alone", 256'(resp_o[2].ack), 256'(0));
        check("postrst_cnt0", 256'(cnt_of(2)), 256'(0));

        step();
        for (int p = 0; p < PORTS; p++) begin
            check($sformatf("final_pending_p%0d", p), 256'(exp_q[p].size()), 256'(0));
            check($sformatf("final_empty_p%0d", p), 256'(resp_o[p]), 256'(empty_v));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fta_resp_router.md
FTA_RESP_ROUTER -- requirements
Module: fta_resp_router

Interface
REQ-001 Parameter PORTS, default 4: number of requester ports; power of two, 2..16.
REQ-002 Parameter DEPTH, default 4: per-port response FIFO entries; power of two, 2..16.
REQ-003 Port clk  input  1: clock; all state updates on rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-high.
REQ-005 Port resp_i  input  fta_cmd_response128_t: serialized response stream from the response buffer; valid when resp_i.ack=1.
REQ-006 Port resp_o  output  fta_cmd_response128_t [PORTS-1:0]: per-port head-of-FIFO response; resp_o[p].ack=1 when port p FIFO is non-empty.
REQ-007 Port rdy_i  input  PORTS: per-port consumer ready; a pop occurs when resp_o[p].ack=1 and rdy_i[p]=1.
REQ-008 Port ovf_o  output  PORTS: per-port sticky overflow flag.
REQ-009 Port ovf_clr_i  input  PORTS: per-port overflow flag clear.
REQ-010 Port cnt_o  output  PORTS*($clog2(DEPTH)+1): per-port FIFO occupancy, port p in slice p.

Function
REQ-011 Routing: destination port = resp_i.cid[$clog2(PORTS)-1:0]; upper cid bits are ignored.
REQ-012 Push: resp_i.ack=1 at edge t writes the full resp_i struct into the destination FIFO tail; the entry is visible on resp_o one cycle later (edge t+1).
REQ-013 resp_i.ack=0: no push; other resp_i fields are ignored.
REQ-014 Empty port: resp_o[p] is all-zero except pri=4'hF; ack=0.
REQ-015 Non-empty port: resp_o[p] equals the stored head entry with ack forced to 1; stall and next are forced to 0.
REQ-016 Ordering: each port delivers responses in arrival order; ports are fully independent.
REQ-017 Pop: resp_o[p].ack & rdy_i[p] at an edge advances the head pointer; the next entry, if any, is presented the following cycle with no bubble.
REQ-018 rdy_i[p] while port p is empty has no effect.
REQ-019 Push and pop on the same port in the same cycle: both take effect; occupancy is unchanged.
REQ-020 Full port (count=DEPTH) with push and no pop: resp_i is discarded, FIFO contents are unchanged, and ovf_o[p] is set at that edge.
REQ-021 Full port with push and pop in the same cycle: the push is accepted and no overflow is flagged.
REQ-022 Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; occupancy is $clog2(DEPTH)+1 bits, range 0..DEPTH.
REQ-023 Overflow flag: ovf_clr_i[p] clears ovf_o[p]; a set and a clear in the same cycle leaves the flag set.
REQ-024 Only the destination port's state changes on a push; no other port's state changes.
REQ-025 cnt_o reflects registered occupancy with no combinational path from inputs.
REQ-026 resp_o depends only on registered state; there is no combinational path from resp_i or rdy_i to resp_o.

Reset
REQ-027 While rst=1, all FIFOs are emptied (pointers and counts = 0), ovf_o=0 and cnt_o=0, and resp_o[p] takes the empty value of REQ-014.
REQ-028 rst asserted mid-operation discards all buffered responses immediately (asynchronously); no entry reappears after reset is released.
REQ-029 FIFO storage contents need not be reset; entries are never visible unless written after reset.
REQ-030 On the first edge after rst deasserts, a response with resp_i.ack=1 is accepted normally.

Verification
REQ-031 Single route: PORTS=4; push cid=2, dat=0xA5, tid=7; rdy_i=0 -> resp_o[2].ack=1 with dat=0xA5 and tid=7 at the next cycle; other ports ack=0; cnt_o[2]=1.
REQ-032 Order and back-to-back pop: push dat 1,2,3 to port 1 on consecutive cycles, then hold rdy_i[1]=1 -> resp_o[1].dat sequence 1,2,3 on consecutive cycles, then ack=0 and count=0.
REQ-033 Overflow: DEPTH=4; push 5 responses to port 0 with rdy_i=0 -> cnt=4, ovf_o[0]=1, head dat = first pushed, and the 5th entry is lost; pulse ovf_clr_i[0] -> ovf_o[0]=0.
REQ-034 Full with simultaneous push and pop: port 3 full, push plus rdy_i[3]=1 in one cycle -> cnt stays 4, ovf_o[3]=0, and the new entry is delivered last.
REQ-035 Wrap-around: 10 push/pop pairs interleaved on port 1 with DEPTH=4 -> all 10 data values delivered in order with no loss.
REQ-036 Reset mid-stream: 3 entries queued on port 2, assert rst for 1 cycle -> resp_o[2].ack=0, pri=4'hF, cnt=0; a push issued after reset is delivered alone.
